// File: rtl/reg_usb_stat_mon.sv
// rtl/reg_usb_stat_mon.sv - register-mapped multi-channel USB STAT pattern monitor
//
// Purpose: each channel compares the registered STAT word against its own
// pattern/mask. It counts qualifying events in level or edge mode and
// captures the first matching value together with its timestamp.
//
// Ports:
//   cwusb_clk      - single clock, rising edge
//   reset_i        - synchronous active-high reset
//   reg_address    - [7:6] block select, [5:0] register offset
//   reg_bytecnt    - byte index inside multi-byte registers
//   read_data      - registered read data, valid the cycle after reg_read
//   write_data     - write data byte
//   reg_read       - read strobe
//   reg_write      - write strobe
//   reg_addrvalid  - address valid
//   arm_i          - external arm, rising edge arms
//   stat_i         - STAT word, already synchronous to cwusb_clk
//   match_o        - per-channel one-cycle pulse on each qualifying event
//   any_captured_o - OR of all channel captured flags
//   selected       - this block is addressed
module reg_usb_stat_mon #(
  parameter int          pBYTECNT_SIZE = 7,
  parameter logic [1:0]  pSELECT       = 2'b10,
  parameter int          pNUM_CH       = 4,
  parameter int          pSTAT_WIDTH   = 5,
  parameter int          pCOUNT_WIDTH  = 16,
  parameter int          pTS_WIDTH     = 24
) (
  input  logic                     cwusb_clk,
  input  logic                     reset_i,
  input  logic [7:0]               reg_address,
  input  logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
  output logic [7:0]               read_data,
  input  logic [7:0]               write_data,
  input  logic                     reg_read,
  input  logic                     reg_write,
  input  logic                     reg_addrvalid,
  input  logic                     arm_i,
  input  logic [pSTAT_WIDTH-1:0]   stat_i,
  output logic [pNUM_CH-1:0]       match_o,
  output logic                     any_captured_o,
  output logic                     selected
);

  localparam int CH_W = (pNUM_CH > 1) ? $clog2(pNUM_CH) : 1;

  localparam logic [5:0] OFF_CTRL    = 6'h00;
  localparam logic [5:0] OFF_CH_SEL  = 6'h01;
  localparam logic [5:0] OFF_CH_CFG  = 6'h02;
  localparam logic [5:0] OFF_STATUS  = 6'h03;
  localparam logic [5:0] OFF_COUNT   = 6'h04;
  localparam logic [5:0] OFF_SUMMARY = 6'h05;

  localparam logic [pBYTECNT_SIZE-1:0] BC0 = pBYTECNT_SIZE'(0);
  localparam logic [pBYTECNT_SIZE-1:0] BC1 = pBYTECNT_SIZE'(1);
  localparam logic [pBYTECNT_SIZE-1:0] BC2 = pBYTECNT_SIZE'(2);

  // State
  logic [pSTAT_WIDTH-1:0]  stat_q;
  logic [pSTAT_WIDTH-1:0]  pattern_q [pNUM_CH];
  logic [pSTAT_WIDTH-1:0]  mask_q    [pNUM_CH];
  logic [1:0]              mode_q    [pNUM_CH];
  logic [pSTAT_WIDTH-1:0]  cap_val_q [pNUM_CH];
  logic [pTS_WIDTH-1:0]    cap_ts_q  [pNUM_CH];
  logic [pCOUNT_WIDTH-1:0] count_q   [pNUM_CH];
  logic [pNUM_CH-1:0]      captured_q;
  logic [pNUM_CH-1:0]      hit_prev_q;
  logic [pNUM_CH-1:0]      match_q;
  logic [pTS_WIDTH-1:0]    ts_q;
  logic [7:0]              ch_sel_q;
  logic [7:0]              read_data_q;
  logic [7:0]              read_data_d;
  logic                    arm_prev_q;

  // Bus decode
  logic            wr_en;
  logic            rd_en;
  logic [5:0]      offset;
  logic            ch_valid;
  logic [CH_W-1:0] ch_idx;
  logic            arm;
  logic            clr_cnt;
  logic            cfg_wr;
  logic            pat_wr;

  assign selected = reg_addrvalid & (reg_address[7:6] == pSELECT);
  assign wr_en    = selected & reg_write;
  assign rd_en    = selected & reg_read;
  assign offset   = reg_address[5:0];
  assign ch_valid = ch_sel_q < 8'(pNUM_CH);
  assign ch_idx   = ch_sel_q[CH_W-1:0];

  assign arm     = (wr_en && offset == OFF_CTRL && write_data[0]) || (arm_i && !arm_prev_q);
  assign clr_cnt = wr_en && offset == OFF_CTRL && write_data[1];
  assign cfg_wr  = wr_en && offset == OFF_CH_CFG && ch_valid;
  // Pattern byte writes also restart capture on the selected channel
  assign pat_wr  = cfg_wr && reg_bytecnt == BC0;

  // Match detection on the registered STAT word
  logic [pNUM_CH-1:0] hit;
  logic [pNUM_CH-1:0] event_c;

  always_comb begin
    hit     = '0;
    event_c = '0;
    for (int c = 0; c < pNUM_CH; c++) begin
      hit[c] = (mode_q[c] == 2'd1 || mode_q[c] == 2'd2) &&
               (((stat_q ^ pattern_q[c]) & mask_q[c]) == '0);
      event_c[c] = (mode_q[c] == 2'd2) ? (hit[c] & ~hit_prev_q[c]) : hit[c];
    end
  end

  // Read mux; byte-indexed registers are shifted down by the byte index so
  // bytes past the end of a field naturally read as zero.
  logic [47:0] status_vec;

  always_comb begin
    read_data_d = '0;
    status_vec  = {32'(cap_ts_q[ch_idx]), 8'(cap_val_q[ch_idx]), 7'b0, captured_q[ch_idx]};
    if (rd_en) begin
      case (offset)
        OFF_CH_SEL: read_data_d = ch_sel_q;
        OFF_CH_CFG: begin
          if (ch_valid) begin
            if (reg_bytecnt == BC0)      read_data_d = 8'(pattern_q[ch_idx]);
            else if (reg_bytecnt == BC1) read_data_d = 8'(mask_q[ch_idx]);
            else if (reg_bytecnt == BC2) read_data_d = {6'b0, mode_q[ch_idx]};
          end
        end
        OFF_STATUS: begin
          if (ch_valid) read_data_d = 8'(status_vec >> {reg_bytecnt, 3'b000});
        end
        OFF_COUNT: begin
          if (ch_valid) read_data_d = 8'(32'(count_q[ch_idx]) >> {reg_bytecnt, 3'b000});
        end
        OFF_SUMMARY: read_data_d = 8'(captured_q);
        default: read_data_d = '0;
      endcase
    end
  end

  always_ff @(posedge cwusb_clk) begin
    if (reset_i) begin
      stat_q      <= '0;
      ts_q        <= '0;
      ch_sel_q    <= '0;
      read_data_q <= '0;
      arm_prev_q  <= 1'b0;
      captured_q  <= '0;
      hit_prev_q  <= '0;
      match_q     <= '0;
      for (int c = 0; c < pNUM_CH; c++) begin
        pattern_q[c] <= '0;
        mask_q[c]    <= '0;
        mode_q[c]    <= '0;
        cap_val_q[c] <= '0;
        cap_ts_q[c]  <= '0;
        count_q[c]   <= '0;
      end
    end else begin
      stat_q      <= stat_i;
      arm_prev_q  <= arm_i;
      read_data_q <= read_data_d;

      if (wr_en && offset == OFF_CH_SEL) ch_sel_q <= write_data;

      if (arm)             ts_q <= '0;
      else if (ts_q != '1) ts_q <= ts_q + pTS_WIDTH'(1);

      for (int c = 0; c < pNUM_CH; c++) begin
        if (cfg_wr && ch_idx == CH_W'(c)) begin
          if (reg_bytecnt == BC0)      pattern_q[c] <= write_data[pSTAT_WIDTH-1:0];
          else if (reg_bytecnt == BC1) mask_q[c]    <= write_data[pSTAT_WIDTH-1:0];
          else if (reg_bytecnt == BC2) mode_q[c]    <= write_data[1:0];
        end

        if (arm) begin
          // Arm drops any event in the same cycle
          match_q[c]    <= 1'b0;
          hit_prev_q[c] <= 1'b0;
          captured_q[c] <= 1'b0;
          cap_val_q[c]  <= '0;
          cap_ts_q[c]   <= '0;
          count_q[c]    <= '0;
        end else begin
          match_q[c] <= event_c[c];

          if (clr_cnt)                                  count_q[c] <= '0;
          else if (event_c[c] && count_q[c] != '1)      count_q[c] <= count_q[c] + pCOUNT_WIDTH'(1);

          if (pat_wr && ch_idx == CH_W'(c)) begin
            hit_prev_q[c] <= 1'b0;
            captured_q[c] <= 1'b0;
            cap_val_q[c]  <= '0;
            cap_ts_q[c]   <= '0;
          end else begin
            hit_prev_q[c] <= hit[c];
            if (event_c[c] && !captured_q[c]) begin
              captured_q[c] <= 1'b1;
              cap_val_q[c]  <= stat_q;
              cap_ts_q[c]   <= ts_q;
            end
          end
        end
      end
    end
  end

  assign read_data      = read_data_q;
  assign match_o        = match_q;
  assign any_captured_o = |captured_q;

endmodule

// File: tb/tb_reg_usb_stat_mon.sv
// tb/tb_reg_usb_stat_mon.sv - scoreboard bench for reg_usb_stat_mon
module tb_reg_usb_stat_mon;

  localparam int NCH  = 4;
  localparam int SW   = 5;
  localparam int CW   = 8;
  localparam int TW   = 8;
  localparam int CMAX = (1 << CW) - 1;
  localparam int TMAX = (1 << TW) - 1;

  logic           clk = 1'b0;
  logic           reset_i = 1'b1;
  logic [7:0]     reg_address = '0;
  logic [6:0]     reg_bytecnt = '0;
  logic [7:0]     read_data;
  logic [7:0]     write_data = '0;
  logic           reg_read = 1'b0;
  logic           reg_write = 1'b0;
  logic           reg_addrvalid = 1'b0;
  logic           arm_i = 1'b0;
  logic [SW-1:0]  stat_i = '0;
  logic [NCH-1:0] match_o;
  logic           any_captured_o;
  logic           selected;

  always #5 clk = ~clk;

  reg_usb_stat_mon #(
    .pBYTECNT_SIZE(7),
    .pSELECT(2'b10),
    .pNUM_CH(NCH),
    .pSTAT_WIDTH(SW),
    .pCOUNT_WIDTH(CW),
    .pTS_WIDTH(TW)
  ) dut (
    .cwusb_clk(clk),
    .reset_i(reset_i),
    .reg_address(reg_address),
    .reg_bytecnt(reg_bytecnt),
    .read_data(read_data),
    .write_data(write_data),
    .reg_read(reg_read),
    .reg_write(reg_write),
    .reg_addrvalid(reg_addrvalid),
    .arm_i(arm_i),
    .stat_i(stat_i),
    .match_o(match_o),
    .any_captured_o(any_captured_o),
    .selected(selected)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int  m;
    int  anyc;
    bit  rdv;
    int  rdexp;
    int  off;
    int  b;
  } exp_t;

  exp_t sb[$];

  // Reference model: channel state kept as plain integers
  int m_pat[NCH], m_msk[NCH], m_mode[NCH];
  int m_cap[NCH], m_capv[NCH], m_capts[NCH], m_cnt[NCH], m_hp[NCH];
  int m_ts, m_stat, m_chsel, m_armp;
  int forced_exp = -1;
  logic [1:0] sel_field = 2'b10;

  function automatic int model_read(input int off, input int b);
    int c;
    int v;
    c = m_chsel;
    v = 0;
    case (off)
      1: v = m_chsel;
      2: if (c < NCH) begin
           if (b == 0) v = m_pat[c];
           else if (b == 1) v = m_msk[c];
           else if (b == 2) v = m_mode[c];
         end
      3: if (c < NCH) begin
           if (b == 0) v = m_cap[c];
           else if (b == 1) v = m_capv[c];
           else if (b >= 2 && (b - 2) < (TW + 7) / 8) v = (m_capts[c] >> (8 * (b - 2))) & 255;
         end
      4: if (c < NCH && b < (CW + 7) / 8) v = (m_cnt[c] >> (8 * b)) & 255;
      5: for (int k = 0; k < NCH; k++) v = v | (m_cap[k] << k);
      default: v = 0;
    endcase
    return v;
  endfunction

  task automatic model_step();
    exp_t e;
    bit sel, wr, rdd, arm, clr, hit, ev, pclr;
    int off, b, wd, anyc;
    e.m = 0; e.anyc = 0; e.rdv = 0; e.rdexp = 0;
    off = int'(reg_address[5:0]);
    b   = int'(reg_bytecnt);
    wd  = int'(write_data);
    e.off = off; e.b = b;
    if (reset_i) begin
      for (int c = 0; c < NCH; c++) begin
        m_pat[c] = 0; m_msk[c] = 0; m_mode[c] = 0; m_cap[c] = 0;
        m_capv[c] = 0; m_capts[c] = 0; m_cnt[c] = 0; m_hp[c] = 0;
      end
      m_ts = 0; m_stat = 0; m_chsel = 0; m_armp = 0;
      e.rdv = 1; e.rdexp = 0;
      sb.push_back(e);
      return;
    end
    sel = reg_addrvalid && (reg_address[7:6] == 2'b10);
    wr  = sel && reg_write;
    rdd = sel && reg_read;
    if (rdd) begin
      e.rdv = 1;
      e.rdexp = (forced_exp >= 0) ? forced_exp : model_read(off, b);
    end
    arm = (wr && off == 0 && wd[0]) || (arm_i && m_armp == 0);
    clr = wr && off == 0 && wd[1];
    for (int c = 0; c < NCH; c++) begin
      hit  = (m_mode[c] == 1 || m_mode[c] == 2) && (((m_stat ^ m_pat[c]) & m_msk[c]) == 0);
      ev   = (m_mode[c] == 2) ? (hit && m_hp[c] == 0) : hit;
      pclr = wr && off == 2 && b == 0 && m_chsel == c;
      if (arm) begin
        m_cap[c] = 0; m_capv[c] = 0; m_capts[c] = 0; m_cnt[c] = 0; m_hp[c] = 0;
      end else begin
        if (ev) e.m = e.m | (1 << c);
        if (clr) m_cnt[c] = 0;
        else if (ev && m_cnt[c] < CMAX) m_cnt[c]++;
        if (pclr) begin
          m_cap[c] = 0; m_capv[c] = 0; m_capts[c] = 0; m_hp[c] = 0;
        end else begin
          if (ev && m_cap[c] == 0) begin
            m_cap[c] = 1; m_capv[c] = m_stat; m_capts[c] = m_ts;
          end
          m_hp[c] = hit;
        end
      end
    end
    m_ts = arm ? 0 : ((m_ts < TMAX) ? m_ts + 1 : TMAX);
    if (wr && off == 2 && m_chsel < NCH) begin
      if (b == 0) m_pat[m_chsel] = wd & ((1 << SW) - 1);
      else if (b == 1) m_msk[m_chsel] = wd & ((1 << SW) - 1);
      else if (b == 2) m_mode[m_chsel] = wd & 3;
    end
    if (wr && off == 1) m_chsel = wd;
    m_stat = int'(stat_i);
    m_armp = int'(arm_i);
    anyc = 0;
    for (int c = 0; c < NCH; c++) anyc = anyc | m_cap[c];
    e.anyc = anyc;
    sb.push_back(e);
  endtask

  // Monitor: outputs are sampled on the falling edge after each update
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("match_o", int'(match_o), e.m);
        chk("any_captured_o", int'(any_captured_o), e.anyc);
        if (e.rdv) chk($sformatf("read_data off=%0d byte=%0d", e.off, e.b), int'(read_data), e.rdexp);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic wr(input int off, input int b, input int d);
    reg_addrvalid = 1'b1;
    reg_address   = {sel_field, 6'(off)};
    reg_bytecnt   = 7'(b);
    write_data    = 8'(d);
    reg_write     = 1'b1;
    step();
    reg_write     = 1'b0;
    reg_addrvalid = 1'b0;
  endtask

  task automatic rd(input int off, input int b, input int exp = -1);
    reg_addrvalid = 1'b1;
    reg_address   = {2'b10, 6'(off)};
    reg_bytecnt   = 7'(b);
    reg_read      = 1'b1;
    forced_exp    = exp;
    step();
    forced_exp    = -1;
    reg_read      = 1'b0;
    reg_addrvalid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  int seq[7] = '{1, 1, 0, 1, 1, 0, 1};
  int favs[4] = '{5, 1, 31, 0};

  initial begin
    int r, off;
    // Reset and empty register map
    reset_i = 1'b1;
    idle(2);
    reset_i = 1'b0;
    for (int o = 0; o < 8; o++) rd(o, 0, 0);
    rd(63, 0, 0);

    // Channel 0 level mode, capture timestamp 10
    wr(1, 0, 0); wr(2, 0, 5); wr(2, 1, 'h1F); wr(2, 2, 1);
    wr(0, 0, 1);
    idle(9);
    stat_i = 5'h05; idle(3);
    stat_i = 5'h00; idle(3);
    rd(4, 0, 3); rd(3, 0, 1); rd(3, 1, 5); rd(3, 2, 10); rd(5, 0, 1);

    // Channel 1 edge mode, channel 2 off
    wr(1, 0, 1); wr(2, 0, 1); wr(2, 1, 1); wr(2, 2, 2);
    wr(1, 0, 2); wr(2, 2, 0);
    wr(0, 0, 1);
    foreach (seq[i]) begin
      stat_i = 5'(seq[i]);
      step();
    end
    stat_i = 5'h00; idle(3);
    wr(1, 0, 1); rd(4, 0, 3);
    wr(1, 0, 2); rd(4, 0, 0);

    // Channel 3 counter saturation, then arm clears
    wr(1, 0, 3); wr(2, 1, 0); wr(2, 2, 1);
    wr(0, 0, 1);
    idle(300);
    rd(4, 0, 'hFF);
    wr(2, 2, 0);
    wr(0, 0, 1);
    rd(4, 0, 0); rd(3, 0, 0);

    // Arm in the same cycle as an event on channel 0
    wr(1, 0, 0);
    stat_i = 5'h05; step();
    wr(0, 0, 1);
    stat_i = 5'h00;
    rd(4, 0, 0);
    rd(4, 0, 1); rd(3, 0, 1); rd(3, 2, 0);

    // Out-of-range channel select
    wr(1, 0, NCH); wr(2, 0, 'h1F); wr(2, 1, 0); wr(2, 2, 1);
    rd(3, 0, 0); rd(2, 0, 0); rd(1, 0, NCH);
    wr(1, 0, 0); rd(2, 0, 5); rd(2, 1, 'h1F); rd(2, 2, 1);
    wr(1, 0, 3); rd(2, 1, 0); rd(2, 2, 0);

    // Reset in the middle of capture activity
    wr(2, 2, 1); wr(0, 0, 1);
    idle(5);
    reset_i = 1'b1; step();
    reset_i = 1'b0;
    rd(5, 0, 0); rd(1, 0, 0); rd(4, 0, 0);

    // Randomised traffic against the model
    for (int n = 0; n < 3000; n++) begin
      stat_i = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'(favs[$urandom_range(0, 3)]);
      if ($urandom_range(0, 40) == 0) arm_i = ~arm_i;
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 399) == 0) begin
        reset_i = 1'b1; step(); reset_i = 1'b0;
      end else if (r < 10) begin
        off = $urandom_range(0, 11);
        if (off > 7) off = 2;
        sel_field = ($urandom_range(0, 7) == 0) ? 2'b01 : 2'b10;
        if (off == 0)      wr(off, 0, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : 2);
        else if (off == 1) wr(off, 0, $urandom_range(0, 5));
        else               wr(off, $urandom_range(0, 3), $urandom_range(0, 255));
        sel_field = 2'b10;
      end else if (r < 22) begin
        rd($urandom_range(0, 7), $urandom_range(0, 4));
      end else begin
        step();
      end
    end

    arm_i = 1'b0;
    idle(3);
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
